serial_alu_sequencer: RTL and testbench

SERIAL_ALU_SEQUENCER -- requirements
Module: serial_alu_sequencer

---
 rtl/serial_alu_sequencer.sv | 165 ++++++++++++++++
 tb/tb_serial_alu_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/serial_alu_sequencer.sv
// Purpose : sequences a WIDTH-bit operation bit-serially (LSB first) through an
//           external combinational 1-bit ALU, assembling RESULT/CARRY/ZERO.
// Latency : START accepted at edge 0 -> BUSY cycles 1..WIDTH -> DONE in cycle
//           WIDTH+1 -> READY in cycle WIDTH+2; illegal MODE -> DONE in cycle 1.
// Backpressure: none; START is only honoured while READY=1 and is ignored
//           otherwise, so a requester must hold off until READY.
// Ports   : CLK/RST (sync, active-high); START/MODE/OP_A/OP_B request;
//           READY/BUSY/DONE status; RESULT/CARRY/ZERO/ERR held results;
//           ALU_MODE/ALU_A/ALU_B/ALU_C_IN drive the 1-bit ALU, ALU_X/ALU_C_OUT
//           return from it combinationally in the same cycle.
module serial_alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] OP_A,
  input  logic [WIDTH-1:0] OP_B,
  output logic             READY,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY,
  output logic             ZERO,
  output logic             ERR,
  output logic [2:0]       ALU_MODE,
  output logic             ALU_A,
  output logic             ALU_B,
  output logic             ALU_C_IN,
  input  logic             ALU_X,
  input  logic             ALU_C_OUT
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [2:0] MODE_ADD  = 3'b000;
  localparam logic [2:0] MODE_XNOR = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [2:0]       mode_q, mode_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      mode_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_sh_q    <= res_sh_d;
      mode_q      <= mode_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_sh_d    = res_sh_q;
    mode_d      = mode_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
    err_d       = err_q;

    READY    = 1'b0;
    BUSY     = 1'b0;
    DONE     = 1'b0;
    ALU_MODE = 3'b000;
    ALU_A    = 1'b0;
    ALU_B    = 1'b0;
    ALU_C_IN = 1'b0;

    case (state_q)
      S_IDLE: begin
        READY = 1'b1;
        if (START) begin
          if (MODE <= MODE_XNOR) begin
            a_sh_d  = OP_A;
            b_sh_d  = OP_B;
            mode_d  = MODE;
            carry_d = 1'b0;
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            // Illegal opcode: skip RUN, keep previous RESULT/CARRY/ZERO.
            err_d   = 1'b1;
            state_d = S_FIN;
          end
        end
      end

      S_RUN: begin
        BUSY     = 1'b1;
        ALU_MODE = mode_q;
        ALU_A    = a_sh_q[0];
        ALU_B    = b_sh_q[0];
        ALU_C_IN = (mode_q == MODE_ADD) ? carry_q : 1'b0;

        // Result enters at the MSB so after WIDTH shifts bit i lines up
        // with operand bit i.
        res_sh_d = {ALU_X, res_sh_q[WIDTH-1:1]};
        carry_d  = ALU_C_OUT;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CW'(1);

        if (cnt_q == LAST_BIT) begin
          // Publish on the final shift edge so RESULT is valid alongside DONE.
          state_d     = S_FIN;
          result_d    = res_sh_d;
          carry_out_d = (mode_q == MODE_ADD) ? ALU_C_OUT : 1'b0;
          zero_d      = (res_sh_d == '0);
          err_d       = 1'b0;
        end
      end

      S_FIN: begin
        DONE    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign RESULT = result_q;
  assign CARRY  = carry_out_q;
  assign ZERO   = zero_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Purpose : directed self-checking bench for serial_alu_sequencer (WIDTH=8)
//           with a behavioural 1-bit ALU closing the ALU_* loop.
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a; every wait for DONE is bounded by a cycle budget.
module tb_serial_alu_sequencer;

  localparam int W = 8;

  logic         CLK, RST, START;
  logic [2:0]   MODE;
  logic [W-1:0] OP_A, OP_B;
  logic         READY, BUSY, DONE, CARRY, ZERO, ERR;
  logic [W-1:0] RESULT;
  logic [2:0]   ALU_MODE;
  logic         ALU_A, ALU_B, ALU_C_IN, ALU_X, ALU_C_OUT;

  int n_checks = 0;
  int n_errors = 0;

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .MODE(MODE),
    .OP_A(OP_A), .OP_B(OP_B),
    .READY(READY), .BUSY(BUSY), .DONE(DONE),
    .RESULT(RESULT), .CARRY(CARRY), .ZERO(ZERO), .ERR(ERR),
    .ALU_MODE(ALU_MODE), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_C_IN(ALU_C_IN),
    .ALU_X(ALU_X), .ALU_C_OUT(ALU_C_OUT)
  );

  // 1-bit ALU: full adder for 000, bitwise logic otherwise.
  always_comb begin
    ALU_X     = 1'b0;
    ALU_C_OUT = 1'b0;
    case (ALU_MODE)
      3'b000: begin
        ALU_X     = ALU_A ^ ALU_B ^ ALU_C_IN;
        ALU_C_OUT = (ALU_A & ALU_B) | (ALU_A & ALU_C_IN) | (ALU_B & ALU_C_IN);
      end
      3'b001:  ALU_X = ALU_A & ALU_B;
      3'b010:  ALU_X = ALU_A | ALU_B;
      3'b011:  ALU_X = ALU_A ^ ALU_B;
      3'b100:  ALU_X = ~(ALU_A ^ ALU_B);
      default: ALU_X = 1'b0;
    endcase
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Launch one operation and follow it to DONE. If inj_cyc > 0, a stray START
  // with junk operands is driven during that RUN cycle and must be ignored.
  task automatic run_op(input string tag, input logic [2:0] m,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input logic exp_c,
                        input logic exp_z, input int inj_cyc);
    int cyc;
    int busy_cnt;
    START = 1'b1; MODE = m; OP_A = a; OP_B = b;
    tick();                       // edge 0
    START = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    check({tag, "_alu_mode"}, 32'(ALU_MODE), 32'(m));
    while (!DONE && cyc < 20) begin
      if (BUSY) busy_cnt++;
      if (cyc == inj_cyc) begin
        START = 1'b1; MODE = 3'b001; OP_A = 8'hFF; OP_B = 8'hFF;
      end
      tick();
      START = 1'b0;
      cyc++;
    end
    check({tag, "_done_cycle"}, 32'(cyc), 32'(W + 1));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    check({tag, "_result"}, 32'(RESULT), 32'(exp_res));
    check({tag, "_carry"}, 32'(CARRY), 32'(exp_c));
    check({tag, "_zero"}, 32'(ZERO), 32'(exp_z));
    check({tag, "_err"}, 32'(ERR), 32'd0);
    check({tag, "_fin_ready"}, 32'(READY), 32'd0);
    tick();
    check({tag, "_ready_after"}, 32'(READY), 32'd1);
    check({tag, "_done_after"}, 32'(DONE), 32'd0);
  endtask

  initial begin
    int seen_done;
    RST = 1'b1; START = 1'b0; MODE = 3'b000; OP_A = '0; OP_B = '0;
    tick();
    tick();
    RST = 1'b0;
    #1;
    check("rst_ready", 32'(READY), 32'd1);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_result", 32'(RESULT), 32'd0);
    check("rst_carry", 32'(CARRY), 32'd0);
    check("rst_zero", 32'(ZERO), 32'd1);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_alu_a", 32'(ALU_A), 32'd0);

    // Hand-computed vectors.
    run_op("add_ff_01", 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 0);
    run_op("and",       3'b001, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 0);
    run_op("or",        3'b010, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 0);
    run_op("xor",       3'b011, 8'hAA, 8'h0F, 8'hA5, 1'b0, 1'b0, 0);
    run_op("xnor",      3'b100, 8'hAA, 8'h0F, 8'h5A, 1'b0, 1'b0, 0);
    run_op("add_7f_01", 3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 0);

    // Illegal opcode: DONE in cycle 1, previous RESULT (0x80) retained.
    START = 1'b1; MODE = 3'b101; OP_A = 8'h11; OP_B = 8'h22;
    tick();
    START = 1'b0;
    check("ill_done", 32'(DONE), 32'd1);
    check("ill_err", 32'(ERR), 32'd1);
    check("ill_busy", 32'(BUSY), 32'd0);
    check("ill_result", 32'(RESULT), 32'h80);
    check("ill_zero", 32'(ZERO), 32'd0);
    tick();
    check("ill_ready_after", 32'(READY), 32'd1);
    check("ill_err_held", 32'(ERR), 32'd1);

    // Mid-op reset during RUN cycle 4.
    START = 1'b1; MODE = 3'b000; OP_A = 8'h55; OP_B = 8'h22;
    tick();                       // cycle 1
    START = 1'b0;
    tick(); tick(); tick();       // cycle 4
    check("mid_busy_c4", 32'(BUSY), 32'd1);
    RST = 1'b1;
    tick();                       // cycle 5
    RST = 1'b0;
    check("mid_ready", 32'(READY), 32'd1);
    check("mid_result", 32'(RESULT), 32'd0);
    check("mid_zero", 32'(ZERO), 32'd1);
    check("mid_err", 32'(ERR), 32'd0);
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (DONE || BUSY) seen_done++;
      tick();
    end
    check("mid_no_done", 32'(seen_done), 32'd0);
    run_op("add_12_34", 3'b000, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 0);

    // Stray START in RUN cycle 3 must not disturb 0x0F + 0x01.
    run_op("ignore_start", 3'b000, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
